// File: rtl/mmd_pkg.sv
// Shared definitions for the multi-modulus divider: default widths, divide limits
// and the FSM state encoding.
package mmd_pkg;

    localparam int MMD_WIDTH   = 4;
    localparam int MMD_MIN_DIV = 3;
    localparam int MMD_MAX_DIV = 15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mmd_divider_if.sv
// Divide-value handshake between the delta-sigma modulator (master) and the divider (slave).
interface mmd_divider_if
    import mmd_pkg::*;
#(
    parameter int WIDTH = MMD_WIDTH
);

    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;

    modport master (output div_in, output div_valid, input div_ready);
    modport slave  (input div_in, input div_valid, output div_ready);

endinterface

// File: rtl/mmd_prefetch.sv
// One-entry prefetch buffer for divide values with ready generation.
// Optional input clamp to MIN_DIV is enabled by defining MMD_CLAMP_EN.
module mmd_prefetch
    import mmd_pkg::*;
#(
    parameter int WIDTH   = MMD_WIDTH,
    parameter int MIN_DIV = MMD_MIN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    mmd_divider_if.slave     bus,
    input  logic             run,
    input  logic             cnt_zero,
    input  logic             start,
    output logic             xfer,
    output logic [WIDTH-1:0] acc_val,
    output logic             nxt_full,
    output logic [WIDTH-1:0] nxt_val,
    output logic             clamp_err
);

    logic             nxt_full_r;
    logic [WIDTH-1:0] nxt_val_r;
    logic             wr_s;
    logic             consume_s;

    assign bus.div_ready = !nxt_full_r || (run && cnt_zero) || !run;
    assign xfer          = bus.div_valid && bus.div_ready;
    // A transfer that feeds a period start directly bypasses an empty buffer.
    assign wr_s          = xfer && !(start && !nxt_full_r);
    assign consume_s     = start && nxt_full_r;
    assign nxt_full      = nxt_full_r;
    assign nxt_val       = nxt_val_r;

`ifdef MMD_CLAMP_EN
    logic below_s;
    logic clamp_err_r;

    assign below_s   = bus.div_in < WIDTH'(MIN_DIV);
    assign acc_val   = below_s ? WIDTH'(MIN_DIV) : bus.div_in;
    assign clamp_err = clamp_err_r;

    // Sticky record of any accepted value below the legal minimum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_err_r <= 1'b0;
        end else begin
            clamp_err_r <= clamp_err_r | (xfer && below_s);
        end
    end
`else
    assign acc_val   = bus.div_in;
    assign clamp_err = 1'b0;
`endif

    // Buffer write wins over consume so a simultaneous refill leaves it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_full_r <= 1'b0;
            nxt_val_r  <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            nxt_full_r <= 1'b1;
            nxt_val_r  <= acc_val;
        end else if (consume_s) begin
            nxt_full_r <= 1'b0;
        end else begin
            nxt_full_r <= nxt_full_r;
        end
    end

endmodule

// File: rtl/mmd_divider.sv
// Programmable multi-modulus divider: one div_pulse per N-cycle period, N fetched per
// period through mmd_prefetch. Build option MMD_CLAMP_EN clamps N below MIN_DIV.
module mmd_divider
    import mmd_pkg::*;
#(
    parameter int WIDTH   = MMD_WIDTH,
    parameter int MIN_DIV = MMD_MIN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    mmd_divider_if.slave     bus,
    output logic             div_pulse,
    output logic [WIDTH-1:0] div_cur,
    output logic             underrun,
    output logic             clamp_err
);

    logic [0:0]       state_r, state_nxt_s;
    logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] cur_r, cur_nxt_s;
    logic             under_r, under_nxt_s;
    logic             pulse_r, pulse_nxt_s;
    logic             cnt_zero_s, start_s, xfer_s, nxt_full_s;
    logic [WIDTH-1:0] acc_val_s, nxt_val_s, load_s;

    mmd_prefetch #(.WIDTH(WIDTH), .MIN_DIV(MIN_DIV)) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .run       (state_r == ST_RUN),
        .cnt_zero  (cnt_zero_s),
        .start     (start_s),
        .xfer      (xfer_s),
        .acc_val   (acc_val_s),
        .nxt_full  (nxt_full_s),
        .nxt_val   (nxt_val_s),
        .clamp_err (clamp_err)
    );

    assign cnt_zero_s = (cnt_r == {WIDTH{1'b0}});
    assign start_s    = enable && (((state_r == ST_IDLE) && (nxt_full_s || xfer_s)) ||
                                   ((state_r == ST_RUN) && cnt_zero_s));
    // With nothing fresh available the running value is reused.
    assign load_s     = nxt_full_s ? nxt_val_s : (xfer_s ? acc_val_s : cur_r);

    // Next-state, counter and period bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cur_nxt_s   = cur_r;
        under_nxt_s = under_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = load_s - WIDTH'(1);
                    cur_nxt_s   = load_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {WIDTH{1'b0}};
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {WIDTH{1'b0}};
                end else if (cnt_zero_s) begin
                    cnt_nxt_s = load_s - WIDTH'(1);
                    cur_nxt_s = load_s;
                    if (!nxt_full_s && !xfer_s) begin
                        under_nxt_s = 1'b1;
                    end else begin
                        under_nxt_s = under_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - WIDTH'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {WIDTH{1'b0}};
            end
        endcase
        pulse_nxt_s = (state_nxt_s == ST_RUN) && (cnt_nxt_s == {WIDTH{1'b0}});
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {WIDTH{1'b0}};
            cur_r   <= {WIDTH{1'b0}};
            under_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cur_r   <= cur_nxt_s;
            under_r <= under_nxt_s;
            pulse_r <= pulse_nxt_s;
        end
    end

    assign div_pulse = pulse_r;
    assign div_cur   = cur_r;
    assign underrun  = under_r;

endmodule

// File: doc/mmd_divider.md
# mmd_divider

Programmable multi-modulus divider that sits directly downstream of the MASH 1-1-1 delta-sigma modulator. It consumes the modulator's 4-bit instantaneous divide value and produces one output pulse every N clock cycles, where N is the value accepted for that period. It takes a new divide value once per output period through a one-entry prefetch buffer with a valid/ready handshake, which lets the modulator be advanced once per divided period.

## Interface
- MIN_DIV, 3, smallest legal divide value; used by the clamp feature
- WIDTH, 4, width of divide value and period counter
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; low returns the block to IDLE at the next edge
- div_in  in  WIDTH  divide value from the modulator output (3..15 legal)
- div_valid  in  1  div_in is valid this cycle
- div_ready  out  1  block accepts div_in this cycle
- div_pulse  out  1  one-cycle pulse in the last cycle of each divided period
- div_cur  out  WIDTH  divide value of the period now running
- underrun  out  1  sticky flag: a period started with no fresh value available
- clamp_err  out  1  sticky flag: a value below MIN_DIV was accepted (MMD_CLAMP_EN only; otherwise tied 0)

## Operation
- Transfer happens when div_valid && div_ready.
- Prefetch buffer: register nxt_val plus flag nxt_full.
- div_ready = !nxt_full || (state==RUN && cnt==0) || state==IDLE.
  - It is combinational from registered state only; it never depends on div_valid.
- States:
  - IDLE: cnt=0, div_pulse=0. A transfer fills the buffer. Go to RUN when enable && (nxt_full || transfer).
  - RUN, period start: cnt loads N-1 and div_cur loads N.
    - N comes from the buffer if it is full, else from the same-cycle transfer.
    - If neither is available, div_cur is reused and underrun is set.
  - RUN, each later cycle: cnt decrements.
  - RUN, cnt==0: this is the last cycle of the period. div_pulse=1 and the next period starts at the following edge.
    - A buffered value is consumed.
    - A same-cycle transfer refills the buffer, or feeds the load directly if the buffer was empty.
- The effective period equals N clock cycles for N≥1. N=0 wraps cnt to 15 and gives a 16-cycle period (no clamp).
- enable low in RUN: go to IDLE at the next edge. The partial period is abandoned with no pulse. The buffer contents are kept.
- Simultaneous consume and transfer at cnt==0: the buffer ends full with the new value. There is no lost or duplicated value.
- div_in is ignored when div_valid is low. Values are taken unsigned.

## Timing
- Reset values:
  - state=IDLE, cnt=0, nxt_full=0, nxt_val=0
  - div_pulse=0, div_cur=0, underrun=0, clamp_err=0
  - div_ready=1
- The first value is accepted in IDLE with enable high at edge k. RUN starts at edge k and the first div_pulse appears in cycle k+N.
- After that, div_pulse repeats every N cycles with no idle gap between periods.
- div_pulse, div_cur and the flags are registered. div_ready is combinational.
- Asynchronous reset mid-period clears everything immediately. There is no pulse on reset release.
- Sticky flags clear only on reset.

## Configuration
- MMD_CLAMP_EN defined:
  - An accepted value < MIN_DIV is replaced by MIN_DIV before buffering.
  - clamp_err is set.
- MMD_CLAMP_EN undefined:
  - Values are used as-is (N=0 gives 16 cycles, N=1 or 2 gives 1 or 2 cycles).
  - clamp_err is constant 0.

## Structure
- Shared package mmd_pkg holds:
  - the state enum (IDLE, RUN)
  - WIDTH default
  - MIN_DIV default
  - the legal maximum 15
- One sub-module is natural: mmd_prefetch, holding the one-entry buffer, ready logic and optional clamp. The counter and FSM stay in mmd_divider.
- Estimated size is about 150-250 lines total.

## Test plan
- Reset, then enable=1 with div_valid held high and div_in=4 constant -> div_pulse every 4 cycles, first pulse 4 cycles after the accept, div_cur=4, underrun=0.
- Sequence 3,5,7,3 presented with valid only when ready -> pulse spacing exactly 3,5,7,3 cycles and div_cur tracks each period.
- After the first accept of 6, div_valid is held low -> periods repeat at 6, underrun=1 at the second period start and stays 1.
- enable dropped 2 cycles into a 9-cycle period, then raised -> no pulse for the aborted period; the buffered value starts the next period and pulse spacing is correct.
- Async rst_n low mid-period with buffer full -> all outputs return to their reset values at once; after release, no pulse until a new value is accepted.
- div_in=1 accepted: with MMD_CLAMP_EN -> 3-cycle period and clamp_err=1; without the macro -> 1-cycle period (div_pulse held high consecutively) and clamp_err=0.
